// File: rtl/calc_key_player.sv
// Command-replay initiator for the RPN calculator CPU: queues Push/Pop/Add/Mult commands,
// presses the CPU pins with fixed timing and captures reported results. Optional: CALC_PLAYER_RESCNT_EN.
module calc_key_player #(
    parameter int PRESS_CYCLES = 2,
    parameter int GAP_CYCLES   = 50,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic       i_clock,
    input  logic       i_rstN,
    input  logic       i_cmdWr,
    input  logic [1:0] i_cmdOp,
    input  logic [7:0] i_cmdData,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_overflow,
    output logic       o_busy,
    output logic [7:0] o_din,
    output logic       o_sample,
    output logic [2:0] o_btns,
    input  logic [7:0] i_dout,
    input  logic       i_dval,
    output logic [7:0] o_result,
    output logic       o_resultStb
`ifdef CALC_PLAYER_RESCNT_EN
    ,output logic [7:0] o_resCount
`endif
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT   = DEPTH[DEPTH_LOG2:0];
    localparam logic [CNT_W-1:0]    PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0]    GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PRESS, S_GAP} state_t;

    logic [9:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    state_t                r_state;
    logic [1:0]            r_op;
    logic [CNT_W-1:0]      r_cnt;
    logic [7:0]            r_din;
    logic                  r_sample;
    logic [2:0]            r_btns;

    logic                  r_dvalQ;
    logic [7:0]            r_result;
    logic                  r_resultStb;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_headOp;
    logic [7:0]            w_headData;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = i_cmdWr && !w_full;
    // The last GAP cycle pops directly so the next SETUP lands exactly GAP_CYCLES after release.
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_GAP) && (r_cnt == '0)));
    assign w_headOp   = r_mem[r_rdPtr][9:8];
    assign w_headData = r_mem[r_rdPtr][7:0];

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {i_cmdOp, i_cmdData};
        end
    end

    always_ff @(posedge i_clock or negedge i_rstN) begin
        if (!i_rstN) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (i_cmdWr && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_rstN) begin
        if (!i_rstN) begin
            r_state  <= S_IDLE;
            r_op     <= OP_PUSH;
            r_cnt    <= '0;
            r_din    <= '0;
            r_sample <= 1'b0;
            r_btns   <= '0;
        end else begin
            if (w_pop) begin
                r_op <= w_headOp;
                if (w_headOp == OP_PUSH) begin
                    r_din <= w_headData;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_state  <= S_PRESS;
                    r_cnt    <= PRESS_LOAD;
                    r_sample <= (r_op == OP_PUSH);
                    r_btns   <= {r_op == OP_POP, r_op == OP_ADD, r_op == 2'd3};
                end
                S_PRESS: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_GAP;
                        r_cnt    <= GAP_LOAD;
                        r_sample <= 1'b0;
                        r_btns   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= w_pop ? S_SETUP : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result capture runs independently of the FSM so late CPU reports are never lost.
    always_ff @(posedge i_clock or negedge i_rstN) begin
        if (!i_rstN) begin
            r_dvalQ     <= 1'b0;
            r_result    <= '0;
            r_resultStb <= 1'b0;
        end else begin
            r_dvalQ     <= i_dval;
            r_resultStb <= i_dval && !r_dvalQ;
            if (i_dval && !r_dvalQ) begin
                r_result <= i_dout;
            end
        end
    end

`ifdef CALC_PLAYER_RESCNT_EN
    logic [7:0] r_resCount;

    always_ff @(posedge i_clock or negedge i_rstN) begin
        if (!i_rstN) begin
            r_resCount <= '0;
        end else if (r_resultStb && (r_resCount != 8'hFF)) begin
            r_resCount <= r_resCount + 8'd1;
        end
    end

    assign o_resCount = r_resCount;
`endif

    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overflow  = r_overflow;
    assign o_busy      = (r_state != S_IDLE);
    assign o_din       = r_din;
    assign o_sample    = r_sample;
    assign o_btns      = r_btns;
    assign o_result    = r_result;
    assign o_resultStb = r_resultStb;

endmodule

// File: tb/tb_calc_key_player.sv
// Self-checking bench for calc_key_player: a small RPN CPU model answers the presses and a
// stack-level reference model predicts press order, operands and reported results.
module tb_calc_key_player;

    localparam int PRESS  = 2;
    localparam int GAP    = 50;
    localparam int DLOG   = 4;
    localparam int PERIOD = 1 + PRESS + GAP;

    typedef struct {
        int         kind;
        logic [7:0] din;
        int         start;
        int         width;
    } press_t;

    logic       clock = 1'b0;
    logic       rstN;
    logic       cmdWr;
    logic [1:0] cmdOp;
    logic [7:0] cmdData;
    logic       full, empty, overflow, busy;
    logic [7:0] din;
    logic       sample;
    logic [2:0] btns;
    logic [7:0] dout;
    logic       dval;
    logic [7:0] result;
    logic       resultStb;
`ifdef CALC_PLAYER_RESCNT_EN
    logic [7:0] resCount;
`endif

    logic       cpuEn = 1'b0;
    logic [7:0] modelDout = 8'd0;
    logic       modelDval = 1'b0;
    logic [7:0] manDout = 8'd0;
    logic       manDval = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int ohErr = 0;
    int dinErr = 0;
    int stbLongErr = 0;

    press_t     pressQ[$];
    press_t     cur;
    logic [3:0] prevLines = 4'd0;
    logic       prevStb = 1'b0;
    logic [7:0] resQ[$];

    logic [1:0] cmdOpQ[$];
    logic [7:0] cmdDataQ[$];
    logic [7:0] expQ[$];
    logic [7:0] refStack[$];

    logic [7:0] cpuStack[$];
    logic [3:0] cpuPrev = 4'd0;
    logic [7:0] cpuOut = 8'd0;
    int         cpuDelay = 0;

    assign dout = cpuEn ? modelDout : manDout;
    assign dval = cpuEn ? modelDval : manDval;

    calc_key_player #(.PRESS_CYCLES(PRESS), .GAP_CYCLES(GAP), .DEPTH_LOG2(DLOG)) dut (
        .i_clock(clock),
        .i_rstN(rstN),
        .i_cmdWr(cmdWr),
        .i_cmdOp(cmdOp),
        .i_cmdData(cmdData),
        .o_full(full),
        .o_empty(empty),
        .o_overflow(overflow),
        .o_busy(busy),
        .o_din(din),
        .o_sample(sample),
        .o_btns(btns),
        .i_dout(dout),
        .i_dval(dval),
        .o_result(result),
        .o_resultStb(resultStb)
`ifdef CALC_PLAYER_RESCNT_EN
        ,.o_resCount(resCount)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    function automatic int kindOf(input logic [3:0] lines);
        if (lines[3]) return 0;
        if (lines[2]) return 1;
        if (lines[1]) return 2;
        return 3;
    endfunction

    // Pin monitor: records each press (line, Din, start cycle, width) and every result strobe.
    always @(negedge clock) begin
        logic [3:0] lines;
        lines = {sample, btns};
        if ($countones(lines) > 1) ohErr++;
        if (resultStb) begin
            resQ.push_back(result);
            if (prevStb) stbLongErr++;
        end
        prevStb = resultStb;
        if (!rstN) begin
            prevLines = 4'd0;
        end else begin
            if (lines != 4'd0 && prevLines == 4'd0) begin
                cur.kind  = kindOf(lines);
                cur.din   = din;
                cur.start = cycle;
                cur.width = 1;
            end else if (lines != 4'd0) begin
                cur.width++;
                if (sample && din != cur.din) dinErr++;
            end else if (prevLines != 4'd0) begin
                pressQ.push_back(cur);
            end
            prevLines = lines;
        end
    end

    // Behavioural RPN CPU: reacts to the rising edge of a press, reports a result a few cycles later.
    always @(negedge clock) begin
        logic [3:0] lines;
        logic [7:0] a, b;
        lines = {sample, btns};
        if (!rstN) begin
            cpuStack.delete();
            modelDval = 1'b0;
            cpuDelay  = 0;
            cpuPrev   = 4'd0;
        end else begin
            if (cpuDelay > 0) begin
                cpuDelay--;
                if (cpuDelay == 3) begin
                    modelDout = cpuOut;
                    modelDval = 1'b1;
                end
                if (cpuDelay == 0) modelDval = 1'b0;
            end
            if (cpuEn && lines != 4'd0 && cpuPrev == 4'd0) begin
                if (lines[3]) begin
                    cpuStack.push_back(din);
                end else if (lines[2]) begin
                    cpuOut = cpuStack.pop_back();
                    cpuDelay = 8;
                end else begin
                    a = cpuStack.pop_back();
                    b = cpuStack.pop_back();
                    cpuOut = lines[1] ? 8'(a + b) : 8'(a * b);
                    cpuStack.push_back(cpuOut);
                    cpuDelay = 8;
                end
            end
            cpuPrev = lines;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data);
        cmdWr   = 1'b1;
        cmdOp   = op;
        cmdData = data;
        @(negedge clock);
        cmdWr   = 1'b0;
    endtask

    task automatic resetDut();
        cmdWr = 1'b0;
        rstN  = 1'b0;
        repeat (2) @(negedge clock);
        refStack.delete();
        rstN = 1'b1;
        @(negedge clock);
    endtask

    // Reference model: pure stack arithmetic over the queued command list.
    task automatic computeExpected();
        logic [7:0] a, b;
        expQ.delete();
        foreach (cmdOpQ[i]) begin
            case (cmdOpQ[i])
                2'd0: refStack.push_back(cmdDataQ[i]);
                2'd1: expQ.push_back(refStack.pop_back());
                default: begin
                    a = refStack.pop_back();
                    b = refStack.pop_back();
                    if (cmdOpQ[i] == 2'd2) a = 8'(int'(a) + int'(b));
                    else                   a = 8'(int'(a) * int'(b));
                    refStack.push_back(a);
                    expQ.push_back(a);
                end
            endcase
        end
    endtask

    task automatic genRandom(input int n);
        int depth;
        logic [1:0] op;
        depth = 0;
        cmdOpQ.delete();
        cmdDataQ.delete();
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op >= 2'd2 && depth < 2) op = 2'd0;
            if (op == 2'd1 && depth < 1) op = 2'd0;
            if (op == 2'd0) depth++;
            else if (op == 2'd1) depth--;
            else depth--;
            cmdOpQ.push_back(op);
            cmdDataQ.push_back(8'($urandom));
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        int k;
        k = 0;
        while ((busy || !empty) && k < maxCycles) begin
            @(negedge clock);
            k++;
        end
        checkOutput("idleTimeout", 32'(k >= maxCycles), 32'd0);
    endtask

    task automatic runBatch();
        int n;
        n = cmdOpQ.size();
        computeExpected();
        pressQ.delete();
        resQ.delete();
        foreach (cmdOpQ[i]) applyStimulus(cmdOpQ[i], cmdDataQ[i]);
        waitIdle(n * PERIOD + 200);
        repeat (15) @(negedge clock);
        checkOutput("pressCount", pressQ.size(), n);
        for (int i = 0; i < n && i < pressQ.size(); i++) begin
            checkOutput("pressKind", pressQ[i].kind, cmdOpQ[i]);
            checkOutput("pressWidth", pressQ[i].width, PRESS);
            if (cmdOpQ[i] == 2'd0) checkOutput("pushDin", pressQ[i].din, cmdDataQ[i]);
            if (i > 0) checkOutput("pressSpacing", pressQ[i].start - pressQ[i-1].start, PERIOD);
        end
        checkOutput("resultCount", resQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < resQ.size(); i++) begin
            checkOutput("resultValue", resQ[i], expQ[i]);
        end
    endtask

    initial begin
        int k;
        rstN    = 1'b0;
        cmdWr   = 1'b0;
        cmdOp   = 2'd0;
        cmdData = 8'd0;
        repeat (3) @(negedge clock);
        checkOutput("rstDin", din, 8'd0);
        checkOutput("rstSample", sample, 1'b0);
        checkOutput("rstBtns", btns, 3'd0);
        checkOutput("rstResult", result, 8'd0);
        checkOutput("rstStb", resultStb, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstOverflow", overflow, 1'b0);
        checkOutput("rstEmpty", empty, 1'b1);
        checkOutput("rstFull", full, 1'b0);
        rstN = 1'b1;
        @(negedge clock);

        $display("[TB] directed Push 2, Push 5, Add");
        cpuEn = 1'b1;
        cmdOpQ = '{2'd0, 2'd0, 2'd2};
        cmdDataQ = '{8'd2, 8'd5, 8'd0};
        runBatch();
        $display("[TB] directed Push -3, Mult");
        cmdOpQ = '{2'd0, 2'd3};
        cmdDataQ = '{8'hFD, 8'd0};
        runBatch();
        checkOutput("multResult", result, 8'hEB);

        $display("[TB] Dval held high");
        cpuEn = 1'b0;
        resQ.delete();
        manDout = 8'd7;
        manDval = 1'b1;
        repeat (10) @(negedge clock);
        manDval = 1'b0;
        repeat (3) @(negedge clock);
        manDout = 8'd9;
        manDval = 1'b1;
        repeat (3) @(negedge clock);
        manDval = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("dvalStrobes", resQ.size(), 2);
        if (resQ.size() == 2) begin
            checkOutput("dvalFirst", resQ[0], 8'd7);
            checkOutput("dvalSecond", resQ[1], 8'd9);
        end

        repeat (2) begin
            $display("[TB] random batch");
            resetDut();
            cpuEn = 1'b1;
            genRandom(12);
            runBatch();
        end

        $display("[TB] overflow");
        cpuEn = 1'b0;
        resetDut();
        applyStimulus(2'd1, 8'd0);
        repeat (3) @(negedge clock);
        checkOutput("ovfStalledEmpty", empty, 1'b1);
        checkOutput("ovfStalledBusy", busy, 1'b1);
        for (int i = 0; i < 16; i++) applyStimulus(2'(i), 8'(i));
        checkOutput("ovfFullAt16", full, 1'b1);
        checkOutput("ovfNotYet", overflow, 1'b0);
        applyStimulus(2'd0, 8'd99);
        checkOutput("ovfSet", overflow, 1'b1);
        checkOutput("ovfStillFull", full, 1'b1);
        repeat (10) @(negedge clock);
        checkOutput("ovfSticky", overflow, 1'b1);
        resetDut();
        checkOutput("ovfCleared", overflow, 1'b0);
        checkOutput("ovfEmptyAfterRst", empty, 1'b1);

        $display("[TB] reset mid-press");
        applyStimulus(2'd0, 8'd5);
        k = 0;
        while (!sample && k < 20) begin
            @(negedge clock);
            k++;
        end
        checkOutput("sampleTimeout", 32'(k >= 20), 32'd0);
        checkOutput("midPressDin", din, 8'd5);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncSample", sample, 1'b0);
        checkOutput("asyncBusy", busy, 1'b0);
        checkOutput("asyncDin", din, 8'd0);
        repeat (2) @(negedge clock);
        rstN = 1'b1;
        @(negedge clock);
        checkOutput("emptyAfterRelease", empty, 1'b1);
        checkOutput("idleAfterRelease", busy, 1'b0);

`ifdef CALC_PLAYER_RESCNT_EN
        $display("[TB] result counter saturation");
        for (int i = 0; i < 300; i++) begin
            manDval = 1'b1;
            @(negedge clock);
            manDval = 1'b0;
            @(negedge clock);
        end
        @(negedge clock);
        checkOutput("resCountSat", resCount, 8'd255);
`endif

        checkOutput("oneHotButtons", ohErr, 0);
        checkOutput("dinStableInSample", dinErr, 0);
        checkOutput("strobeWidth", stbLongErr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
